// File: rtl/pipelined_add_sub.sv
// Pipelined N-bit adder/subtractor, one W-bit chunk rippled per stage.
// Valid/ready handshake with a global advance; flags registered with the sum.
module pipelined_add_sub #(
    parameter int N      = 32,
    parameter int STAGES = 4
) (
    input  logic         i_CLK,
    input  logic         i_RST,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N-1:0] i_A,
    input  logic [N-1:0] i_B,
    input  logic         i_sub,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [N-1:0] o_S,
    output logic         o_cout,
    output logic         o_ovfl,
    output logic         o_zero
);

    localparam int W = N / STAGES;
    localparam int L = STAGES - 1;

    if (STAGES < 1) begin : g_bad_stages
        $error("pipelined_add_sub: STAGES must be >= 1");
    end
    if ((N % STAGES) != 0) begin : g_bad_split
        $error("pipelined_add_sub: N must be a multiple of STAGES");
    end

    logic [N-1:0] a_q  [STAGES];
    logic [N-1:0] b_q  [STAGES];
    logic [N-1:0] s_q  [STAGES];
    logic         c_q  [STAGES];
    logic         v_q  [STAGES];

    logic [N-1:0] a_in [STAGES];
    logic [N-1:0] b_in [STAGES];
    logic [N-1:0] s_in [STAGES];
    logic         c_in [STAGES];
    logic         v_in [STAGES];
    logic [W:0]   sum_k[STAGES];
    logic [N-1:0] s_nx [STAGES];

    logic ovfl_q;
    logic zero_q;
    logic adv;

    assign adv     = ~v_q[L] | i_ready;
    assign o_ready = adv;
    assign o_valid = v_q[L];
    assign o_S     = s_q[L];
    assign o_cout  = c_q[L];
    assign o_ovfl  = ovfl_q;
    assign o_zero  = zero_q;

    // Stage 0 takes conditioned operands; later stages take the previous register.
    always_comb begin
        a_in[0] = i_A;
        b_in[0] = i_sub ? ~i_B : i_B;
        s_in[0] = '0;
        c_in[0] = i_sub;
        v_in[0] = i_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_in[k] = a_q[k-1];
            b_in[k] = b_q[k-1];
            s_in[k] = s_q[k-1];
            c_in[k] = c_q[k-1];
            v_in[k] = v_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            sum_k[k] = {1'b0, a_in[k][k*W +: W]}
                     + {1'b0, b_in[k][k*W +: W]}
                     + {{W{1'b0}}, c_in[k]};
            s_nx[k] = s_in[k];
            s_nx[k][k*W +: W] = sum_k[k][W-1:0];
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
            end
            ovfl_q <= 1'b0;
            zero_q <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= v_in[k];
                a_q[k] <= a_in[k];
                b_q[k] <= b_in[k];
                s_q[k] <= s_nx[k];
                c_q[k] <= sum_k[k][W];
            end
            ovfl_q <= (a_in[L][N-1] == b_in[L][N-1])
                    & (s_nx[L][N-1] != a_in[L][N-1]);
            zero_q <= ~|s_nx[L];
        end
    end

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Directed bench for pipelined_add_sub: 32/4, 32/1 and 8/2 instances.
// Expected values are hand-computed constants.
module tb_pipelined_add_sub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        vin, rdy_in, sub;
    logic [31:0] a, b;
    logic        rdy_out, vout, cout, ovfl, zero;
    logic [31:0] s;

    logic        v1, sub1;
    logic [31:0] a1, b1;
    logic        rdy1, vo1, c1, ov1, z1;
    logic [31:0] s1;

    logic        v8, sub8;
    logic [7:0]  a8, b8;
    logic        rdy8, vo8, c8, ov8, z8;
    logic [7:0]  s8;

    logic        one = 1'b1;

    pipelined_add_sub #(.N(32), .STAGES(4)) u_dut (
        .i_CLK(clk), .i_RST(rst), .i_valid(vin), .o_ready(rdy_out),
        .i_A(a), .i_B(b), .i_sub(sub), .o_valid(vout), .i_ready(rdy_in),
        .o_S(s), .o_cout(cout), .o_ovfl(ovfl), .o_zero(zero)
    );

    pipelined_add_sub #(.N(32), .STAGES(1)) u_s1 (
        .i_CLK(clk), .i_RST(rst), .i_valid(v1), .o_ready(rdy1),
        .i_A(a1), .i_B(b1), .i_sub(sub1), .o_valid(vo1), .i_ready(one),
        .o_S(s1), .o_cout(c1), .o_ovfl(ov1), .o_zero(z1)
    );

    pipelined_add_sub #(.N(8), .STAGES(2)) u_n8 (
        .i_CLK(clk), .i_RST(rst), .i_valid(v8), .o_ready(rdy8),
        .i_A(a8), .i_B(b8), .i_sub(sub8), .o_valid(vo8), .i_ready(one),
        .o_S(s8), .o_cout(c8), .o_ovfl(ov8), .o_zero(z8)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // expected word = {cout, ovfl, zero, S}
    task automatic try32(input string tag, input logic [31:0] xa,
                         input logic [31:0] xb, input logic xs,
                         input logic [34:0] exp);
        int lat;
        @(negedge clk);
        vin = 1'b1; a = xa; b = xb; sub = xs;
        lat = 0;
        do begin
            @(negedge clk);
            vin = 1'b0;
            lat++;
        end while (!vout && lat < 20);
        check({tag, "_lat"}, 64'(lat), 64'd4);
        check(tag, {29'd0, cout, ovfl, zero, s}, {29'd0, exp});
    endtask

    task automatic try_s1(input string tag, input logic [31:0] xa,
                          input logic [31:0] xb, input logic xs,
                          input logic [34:0] exp);
        int lat;
        @(negedge clk);
        v1 = 1'b1; a1 = xa; b1 = xb; sub1 = xs;
        lat = 0;
        do begin
            @(negedge clk);
            v1 = 1'b0;
            lat++;
        end while (!vo1 && lat < 20);
        check({tag, "_lat"}, 64'(lat), 64'd1);
        check(tag, {29'd0, c1, ov1, z1, s1}, {29'd0, exp});
    endtask

    task automatic try_n8(input string tag, input logic [7:0] xa,
                          input logic [7:0] xb, input logic xs,
                          input logic [10:0] exp);
        int lat;
        @(negedge clk);
        v8 = 1'b1; a8 = xa; b8 = xb; sub8 = xs;
        lat = 0;
        do begin
            @(negedge clk);
            v8 = 1'b0;
            lat++;
        end while (!vo8 && lat < 20);
        check({tag, "_lat"}, 64'(lat), 64'd2);
        check(tag, {53'd0, c8, ov8, z8, s8}, {53'd0, exp});
    endtask

    logic [31:0] opa [8];
    logic [31:0] opb [8];
    logic        ops [8];
    logic [34:0] ope [8];

    initial begin
        opa[0] = 32'h0000_0001; opb[0] = 32'h0000_0002; ops[0] = 0;
        ope[0] = {3'b000, 32'h0000_0003};
        opa[1] = 32'h0000_00FF; opb[1] = 32'h0000_0001; ops[1] = 0;
        ope[1] = {3'b000, 32'h0000_0100};
        opa[2] = 32'h1234_5678; opb[2] = 32'h1111_1111; ops[2] = 0;
        ope[2] = {3'b000, 32'h2345_6789};
        opa[3] = 32'hFFFF_FFFF; opb[3] = 32'h0000_0002; ops[3] = 0;
        ope[3] = {3'b100, 32'h0000_0001};
        opa[4] = 32'h0000_0010; opb[4] = 32'h0000_0010; ops[4] = 1;
        ope[4] = {3'b101, 32'h0000_0000};
        opa[5] = 32'h0001_0000; opb[5] = 32'h0000_0001; ops[5] = 1;
        ope[5] = {3'b100, 32'h0000_FFFF};
        opa[6] = 32'h8000_0000; opb[6] = 32'h8000_0000; ops[6] = 0;
        ope[6] = {3'b111, 32'h0000_0000};
        opa[7] = 32'hDEAD_BEEF; opb[7] = 32'h0000_0000; ops[7] = 0;
        ope[7] = {3'b000, 32'hDEAD_BEEF};
    end

    initial begin
        int rx, tx, first, last, stalls, seen;
        rst = 1'b1; rdy_in = 1'b1;
        vin = 0; a = '0; b = '0; sub = 0;
        v1 = 0; a1 = '0; b1 = '0; sub1 = 0;
        v8 = 0; a8 = '0; b8 = '0; sub8 = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out", {59'd0, vout, cout, ovfl, zero, 32'd0} | 64'(s), 64'd0);
        check("rst_ready", 64'(rdy_out), 64'd1);
        check("rst_s1", {29'd0, vo1, c1, ov1, z1, s1} , 64'd0);
        check("rst_n8", {52'd0, vo8, c8, ov8, z8, s8}, 64'd0);

        try32("add_chunk", 32'h0000_FFFF, 32'h0000_0001, 0, {3'b000, 32'h0001_0000});
        try32("add_ovfl",  32'h7FFF_FFFF, 32'h0000_0001, 0, {3'b010, 32'h8000_0000});
        try32("add_wrap",  32'hFFFF_FFFF, 32'h0000_0001, 0, {3'b101, 32'h0000_0000});
        try32("sub_neg",   32'h0000_0005, 32'h0000_0007, 1, {3'b000, 32'hFFFF_FFFE});
        try32("sub_ovfl",  32'h8000_0000, 32'h0000_0001, 1, {3'b110, 32'h7FFF_FFFF});

        rx = 0; first = -1; last = -1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (vout) begin
                if (rx < 8)
                    check($sformatf("stream%0d", rx),
                          {29'd0, cout, ovfl, zero, s}, {29'd0, ope[rx]});
                if (rx == 0) first = cyc;
                last = cyc;
                rx++;
            end
            vin = (cyc < 8);
            if (cyc < 8) begin
                a = opa[cyc]; b = opb[cyc]; sub = ops[cyc];
            end
        end
        vin = 1'b0;
        check("stream_first", 64'(first), 64'd4);
        check("stream_last", 64'(last), 64'd11);
        check("stream_count", 64'(rx), 64'd8);

        rx = 0; tx = 0; stalls = 0;
        for (int cyc = 0; cyc < 40 && rx < 6; cyc++) begin
            @(negedge clk);
            rdy_in = !(rx == 2 && stalls < 3);
            vin = (tx < 6);
            if (tx < 6) begin
                a = opa[tx]; b = opb[tx]; sub = ops[tx];
            end
            #1;
            if (vout && rdy_in) begin
                check($sformatf("bp%0d", rx),
                      {29'd0, cout, ovfl, zero, s}, {29'd0, ope[rx]});
                rx++;
            end else if (vout) begin
                check("bp_ready", 64'(rdy_out), 64'd0);
                check("bp_hold", {29'd0, cout, ovfl, zero, s}, {29'd0, ope[rx]});
                stalls++;
            end
            if (vin && rdy_out) tx++;
        end
        @(negedge clk);
        vin = 1'b0; rdy_in = 1'b1;
        check("bp_count", 64'(rx), 64'd6);
        check("bp_stalls", 64'(stalls), 64'd3);
        repeat (6) @(negedge clk);
        check("bp_drain", 64'(vout), 64'd0);

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vin = 1'b1; a = opa[i]; b = opb[i]; sub = ops[i];
        end
        @(negedge clk);
        vin = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_out", {59'd0, vout, cout, ovfl, zero, 32'd0} | 64'(s), 64'd0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (vout) seen++;
        end
        check("mid_rst_lost", 64'(seen), 64'd0);
        try32("post_rst", 32'h1234_5678, 32'h1111_1111, 0, {3'b000, 32'h2345_6789});

        try_s1("s1_chunk", 32'h0000_FFFF, 32'h0000_0001, 0, {3'b000, 32'h0001_0000});
        try_s1("s1_ovfl",  32'h7FFF_FFFF, 32'h0000_0001, 0, {3'b010, 32'h8000_0000});
        try_s1("s1_wrap",  32'hFFFF_FFFF, 32'h0000_0001, 0, {3'b101, 32'h0000_0000});

        try_n8("n8_chunk", 8'h0F, 8'h01, 0, {3'b000, 8'h10});
        try_n8("n8_ovfl",  8'h7F, 8'h01, 0, {3'b010, 8'h80});
        try_n8("n8_wrap",  8'hFF, 8'h01, 0, {3'b101, 8'h00});
        try_n8("n8_sub",   8'h05, 8'h07, 1, {3'b000, 8'hFE});

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
